// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory for an RV32I core.
// Fixed-latency responses with byte/half/word load-store decoding.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [31:0]           reqAddr,
  input  logic [2:0]            reqFunc3,
  input  logic [DATA_WIDTH-1:0] reqWdata,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspRdata,
  output logic                  rspErr
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, stateNxt;
  logic [3:0] cnt, cntNxt;

  logic          wrR;
  logic [31:0]   addrR;
  logic [2:0]    f3R;
  logic [DW-1:0] wdataR;
  logic [DW-1:0] rdataR;
  logic          errR;

  logic [DW-1:0] mem [MEM_DEPTH];

  logic          accept;
  logic          commit;
  logic          cWr;
  logic [31:0]   cAddr;
  logic [2:0]    cF3;
  logic [DW-1:0] cWdata;
  logic          badF3;
  logic          misal;
  logic          oor;
  logic          cErr;
  logic [AW-1:0] cIdx;
  logic [DW-1:0] cWord;
  logic [DW-1:0] lane;
  logic [DW-1:0] ldData;
  logic [DW-1:0] wMask;
  logic [DW-1:0] wVal;

  assign reqReady = (state == IDLE);
  assign rspValid = (state == RESP);
  assign rspRdata = rspValid ? rdataR : '0;
  assign rspErr   = rspValid & errR;
  assign accept   = reqReady & reqValid;
  assign commit   = rstN & (stateNxt == RESP)
                  & (state != RESP);

  // With LATENCY=1 the commit edge is the accept edge, so use live inputs.
  assign cWr    = (state == IDLE) ? reqWrite : wrR;
  assign cAddr  = (state == IDLE) ? reqAddr  : addrR;
  assign cF3    = (state == IDLE) ? reqFunc3 : f3R;
  assign cWdata = (state == IDLE) ? reqWdata : wdataR;

  assign cIdx  = cAddr[AW+1:2];
  assign cWord = mem[cIdx];
  assign lane  = cWord >> {cAddr[1:0], 3'b000};

  // Next state and latency counter.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    unique case (state)
      IDLE: begin
        if (reqValid) begin
          if (LATENCY > 1) begin
            stateNxt = WAIT;
            cntNxt   = CNT_INIT;
          end else begin
            stateNxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          stateNxt = RESP;
          cntNxt   = 4'd0;
        end else begin
          cntNxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rspReady) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Access legality: func3 code, alignment and range.
  always_comb begin
    badF3 = (cF3[1:0] == 2'b11)
          | (cF3[2] & (cWr | cF3[1]));
    misal = ((cF3[1:0] == 2'b01) & cAddr[0])
          | ((cF3[1:0] == 2'b10) & (|cAddr[1:0]));
    oor   = {2'b00, cAddr[31:2]} >= 32'(MEM_DEPTH);
    cErr  = badF3 | misal | oor;
  end

  // Load lane select and extension.
  always_comb begin
    ldData = cWord;
    case (cF3)
      3'b000: ldData = {{(DW-8){lane[7]}}, lane[7:0]};
      3'b001: ldData = {{(DW-16){lane[15]}}, lane[15:0]};
      3'b100: ldData = {{(DW-8){1'b0}}, lane[7:0]};
      3'b101: ldData = {{(DW-16){1'b0}}, lane[15:0]};
      default: ldData = cWord;
    endcase
  end

  // Store lane mask and shifted data.
  always_comb begin
    wMask = '1;
    wVal  = cWdata;
    case (cF3[1:0])
      2'b00: begin
        wMask = {{(DW-8){1'b0}}, 8'hFF}
              << {cAddr[1:0], 3'b000};
        wVal  = {{(DW-8){1'b0}}, cWdata[7:0]}
              << {cAddr[1:0], 3'b000};
      end
      2'b01: begin
        wMask = {{(DW-16){1'b0}}, 16'hFFFF}
              << {cAddr[1:0], 3'b000};
        wVal  = {{(DW-16){1'b0}}, cWdata[15:0]}
              << {cAddr[1:0], 3'b000};
      end
      default: begin
        wMask = '1;
        wVal  = cWdata;
      end
    endcase
  end

  // State register and counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Capture the request on accept.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrR    <= 1'b0;
      addrR  <= '0;
      f3R    <= '0;
      wdataR <= '0;
    end else if (accept) begin
      wrR    <= reqWrite;
      addrR  <= reqAddr;
      f3R    <= reqFunc3;
      wdataR <= reqWdata;
    end
  end

  // Response payload sampled at the commit edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdataR <= '0;
      errR   <= 1'b0;
    end else if (commit) begin
      errR   <= cErr;
      rdataR <= (cErr | cWr) ? '0 : ldData;
    end
  end

  // Storage is never reset; legal stores merge their lanes at commit.
  always_ff @(posedge clk) begin
    if (commit && cWr && !cErr) begin
      mem[cIdx] <= (cWord & ~wMask) | (wVal & wMask);
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random load/store traffic
// checked against a byte-addressed reference memory.
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [2:0]  reqFunc3;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [0:1023];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_WIDTH(32),
    .MEM_DEPTH(256),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqWrite(reqWrite),
    .reqAddr(reqAddr),
    .reqFunc3(reqFunc3),
    .reqWdata(reqWdata),
    .rspValid(rspValid),
    .rspReady(rspReady),
    .rspRdata(rspRdata),
    .rspErr(rspErr)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, 1024 bytes.
  function automatic void model(input logic w,
                                input logic [31:0] a,
                                input logic [2:0] f,
                                input logic [31:0] wd,
                                output logic [31:0] rd,
                                output logic er);
    int size;
    bit legal;
    longint v;
    size = 1 << f[1:0];
    if (w) legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
    else legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2)
              || (f == 3'd4) || (f == 3'd5);
    er = !legal || ((a % size) != 0) || ((a / 4) >= 256);
    rd = 32'd0;
    v = 0;
    if (er) return;
    if (w) begin
      for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++)
        v += longint'(mb[a + i]) << (8 * i);
      if (!f[2] && size < 4 && mb[a + size - 1][7])
        v -= longint'(1) << (8 * size);
      rd = v[31:0];
    end
  endfunction

  // One full transaction; starts and ends at a negedge in IDLE.
  task automatic xact(input logic w,
                      input logic [31:0] a,
                      input logic [2:0] f,
                      input logic [31:0] wd,
                      input int hold,
                      input string tag,
                      output logic [31:0] obsD);
    logic [31:0] expD;
    logic expE;
    int k;
    check($sformatf("%s.rdy", tag), 32'(reqReady), 32'd1);
    reqValid = 1'b1;
    reqWrite = w;
    reqAddr  = a;
    reqFunc3 = f;
    reqWdata = wd;
    rspReady = (hold == 0);
    @(posedge clk);
    model(w, a, f, wd, expD, expE);
    @(negedge clk);
    reqValid = 1'(($urandom));
    reqWrite = 1'(($urandom));
    reqAddr  = $urandom;
    reqFunc3 = 3'(($urandom));
    reqWdata = $urandom;
    k = 1;
    while (!rspValid && k < 40) begin
      check($sformatf("%s.qd", tag), rspRdata, 32'd0);
      check($sformatf("%s.qe", tag), 32'(rspErr), 32'd0);
      check($sformatf("%s.busy", tag), 32'(reqReady), 32'd0);
      @(negedge clk);
      k++;
    end
    reqValid = 1'b0;
    obsD = rspRdata;
    check($sformatf("%s.lat", tag), 32'(k), 32'(LAT));
    check($sformatf("%s.data", tag), rspRdata, expD);
    check($sformatf("%s.err", tag), 32'(rspErr), 32'(expE));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s.hv", tag), 32'(rspValid), 32'd1);
      check($sformatf("%s.hd", tag), rspRdata, expD);
      check($sformatf("%s.he", tag), 32'(rspErr), 32'(expE));
      check($sformatf("%s.hr", tag), 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    check($sformatf("%s.done", tag), 32'(rspValid), 32'd0);
    check($sformatf("%s.rdy2", tag), 32'(reqReady), 32'd1);
    rspReady = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] dd;
    logic de;
    logic [31:0] ra;
    logic [2:0] rf;
    logic rw;

    rstN = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr = '0;
    reqFunc3 = '0;
    reqWdata = '0;
    rspReady = 1'b0;
    #12;
    check("rst.rdy", 32'(reqReady), 32'd1);
    check("rst.vld", 32'(rspValid), 32'd0);
    check("rst.data", rspRdata, 32'd0);
    check("rst.err", 32'(rspErr), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 256; i++)
      xact(1'b1, 32'(i * 4), 3'd2, $urandom, 0, "init", d);

    xact(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, "sw10", d);
    xact(1'b0, 32'h10, 3'd2, 32'h0, 0, "lw10", d);
    check("lw10.k", d, 32'hDEADBEEF);
    xact(1'b0, 32'h13, 3'd0, 32'h0, 0, "lb13", d);
    check("lb13.k", d, 32'hFFFFFFDE);
    xact(1'b0, 32'h13, 3'd4, 32'h0, 0, "lbu13", d);
    check("lbu13.k", d, 32'h000000DE);
    xact(1'b0, 32'h10, 3'd1, 32'h0, 0, "lh10", d);
    check("lh10.k", d, 32'hFFFFBEEF);
    xact(1'b0, 32'h12, 3'd5, 32'h0, 0, "lhu12", d);
    check("lhu12.k", d, 32'h0000DEAD);
    xact(1'b1, 32'h11, 3'd0, 32'hAAAA0055, 0, "sb11", d);
    xact(1'b0, 32'h10, 3'd2, 32'h0, 0, "lw10b", d);
    check("lw10b.k", d, 32'hDEAD55EF);

    xact(1'b0, 32'h12, 3'd2, 32'h0, 0, "e.lw12", d);
    xact(1'b1, 32'h11, 3'd1, 32'h1234, 0, "e.sh11", d);
    xact(1'b0, 32'h10, 3'd3, 32'h0, 0, "e.f3", d);
    xact(1'b1, 32'h10, 3'd4, 32'h77, 0, "e.sf3", d);
    xact(1'b0, 32'h400, 3'd2, 32'h0, 0, "e.oor", d);
    xact(1'b0, 32'h10, 3'd2, 32'h0, 0, "lw10c", d);
    check("lw10c.k", d, 32'hDEAD55EF);

    xact(1'b0, 32'h10, 3'd2, 32'h0, 5, "hold", d);

    xact(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 0, "sw20", d);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddr = 32'h20;
    reqFunc3 = 3'd2;
    reqWdata = 32'h12345678;
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    rstN = 1'b0;
    #1;
    check("rw.rdy", 32'(reqReady), 32'd1);
    check("rw.vld", 32'(rspValid), 32'd0);
    check("rw.data", rspRdata, 32'd0);
    check("rw.err", 32'(rspErr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    rspReady = 1'b0;
    xact(1'b0, 32'h20, 3'd2, 32'h0, 0, "lw20", d);
    check("lw20.k", d, 32'hCAFEF00D);

    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddr = 32'h24;
    reqFunc3 = 3'd2;
    reqWdata = 32'h0BADC0DE;
    rspReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    check("rr.vld", 32'(rspValid), 32'd1);
    model(1'b1, 32'h24, 3'd2, 32'h0BADC0DE, dd, de);
    rstN = 1'b0;
    #1;
    check("rr.vld0", 32'(rspValid), 32'd0);
    check("rr.rdy", 32'(reqReady), 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    xact(1'b0, 32'h24, 3'd2, 32'h0, 0, "lw24", d);
    check("lw24.k", d, 32'h0BADC0DE);

    for (int n = 0; n < 300; n++) begin
      rw = 1'(($urandom));
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 32'h2000);
      else ra = $urandom_range(0, 1023);
      if ($urandom_range(0, 4) == 0) rf = 3'(($urandom));
      else if (rw) rf = 3'($urandom_range(0, 2));
      else begin
        rf = 3'($urandom_range(0, 4));
        if (rf == 3'd3) rf = 3'd5;
      end
      if ($urandom_range(0, 3) == 0) begin
        if (rf[1:0] == 2'b01) ra[0] = 1'b0;
        if (rf[1:0] == 2'b10) ra[1:0] = 2'b00;
      end
      xact(rw, ra, rf, $urandom, $urandom_range(0, 3), "rnd", d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of load/store data.
REQ-002 SHALL have parameter MEM_DEPTH, default 256: number of DATA_WIDTH-bit words stored.
REQ-003 SHALL have parameter LATENCY, default 2 (legal range 1..15): cycles from request accept to rspValid.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port reqValid, input, 1 bit: the core presents a load or store.
REQ-007 SHALL have port reqReady, output, 1 bit: the responder can accept a request.
REQ-008 SHALL have port reqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port reqAddr, input, 32 bits: byte address.
REQ-010 SHALL have port reqFunc3, input, 3 bits: RV32I width/sign code.
REQ-011 SHALL have port reqWdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-012 SHALL have port rspValid, output, 1 bit: a response is available.
REQ-013 SHALL have port rspReady, input, 1 bit: the core consumes the response.
REQ-014 SHALL have port rspRdata, output, DATA_WIDTH bits: load data, extended per func3.
REQ-015 SHALL have port rspErr, output, 1 bit: the request was misaligned, out of range or had an illegal func3.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP, and support one outstanding request.
REQ-017 SHALL assert reqReady only in IDLE; a request is accepted when reqValid and reqReady are both high on a rising edge.
REQ-018 SHALL register reqWrite, reqAddr, reqFunc3 and reqWdata on accept; request inputs are ignored at all other times.
REQ-019 SHALL transition IDLE -> WAIT on accept when LATENCY>1, loading a down-counter with LATENCY-1.
REQ-020 SHALL transition IDLE -> RESP on accept when LATENCY=1.
REQ-021 SHALL decrement the counter in WAIT and transition WAIT -> RESP when the counter reaches 1, so that rspValid rises exactly LATENCY cycles after the accept edge.
REQ-022 SHALL in RESP hold rspValid=1 with rspRdata and rspErr stable until rspReady=1, then go to IDLE on that edge.
REQ-023 SHALL NOT accept a new request on the RESP exit cycle; reqReady rises the cycle after the RESP exit.
REQ-024 SHALL perform a store's memory write and sample a load's memory word on the edge that enters RESP (the commit point).
REQ-025 SHALL decode loads as LB=000, LH=001, LW=010, LBU=100, LHU=101; a byte or half is selected by addr[1:0]/addr[1] and is sign- or zero-extended to DATA_WIDTH.
REQ-026 SHALL decode stores as SB=000, SH=001, SW=010, updating only the addressed byte lanes with reqWdata[7:0] or [15:0] or the full word.
REQ-027 SHALL flag an error when a halfword has addr[0]=1, a word has addr[1:0]!=0, any other func3 code is used, or addr[31:2] >= MEM_DEPTH.
REQ-028 SHALL, for a flagged error, set rspErr=1 and rspRdata=0, and leave memory unmodified.
REQ-029 SHALL return rspRdata=0 and rspErr=0 for a successful store, which still completes the handshake.
REQ-030 SHALL drive rspRdata=0 and rspErr=0 whenever rspValid=0.
REQ-031 SHALL NOT reset the memory array; its contents are undefined until written.

Reset
REQ-032 SHALL, on rstN low and asynchronously, force state=IDLE, counter=0, reqReady=1, rspValid=0, rspRdata=0 and rspErr=0.
REQ-033 SHALL discard a store when reset asserts before its commit edge; memory is unchanged.
REQ-034 SHALL leave a write that has already committed intact when reset asserts in RESP.
REQ-035 SHALL accept requests from the first rising edge after rstN deasserts.

Verification
REQ-036 SHALL be verified by this scenario (LATENCY=2): SW addr 0x10, data 0xDEADBEEF, then LW addr 0x10 -> store rspValid at accept+2 with rspErr=0; load returns rspRdata=0xDEADBEEF.
REQ-037 SHALL be verified by this scenario: after REQ-036, LB addr 0x13 -> 0xFFFFFFDE; LBU addr 0x13 -> 0x000000DE; LH addr 0x10 -> 0xFFFFBEEF; LHU addr 0x12 -> 0x0000DEAD.
REQ-038 SHALL be verified by this scenario: SB addr 0x11, data 0x55, then LW addr 0x10 -> 0xDEAD55EF.
REQ-039 SHALL be verified by this scenario: LW addr 0x12, SH addr 0x11, func3=011, and LW addr 0x400 -> each gives rspErr=1 and rspRdata=0; a following LW addr 0x10 is unchanged.
REQ-040 SHALL be verified by this scenario: rspReady held low for 5 cycles in RESP -> rspValid, rspRdata and rspErr stable and reqReady=0 throughout; reqReady=1 one cycle after rspReady is asserted.
REQ-041 SHALL be verified by this scenario: SW addr 0x20, data 0x12345678, with rstN pulsed low in WAIT -> all outputs take reset values immediately; a later LW addr 0x20 does not return 0x12345678 unless that value was written before.
